// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-port round-robin command arbiter and sequencer for an
// APB master. Only one transfer is outstanding at a time.
//
// Ports:
//   PCLK, PRESET             clock, synchronous active-high reset
//   reqN_valid/ready         command handshake (ready is combinational, IDLE only)
//   reqN_write/addr/wdata/strb  command payload
//   rspN_valid/rdata/err     one-cycle response to the owning requester
//   transfer                 one-cycle start pulse to the master
//   m_pwrite/paddr/pwdata/pstrb  command to the master, held from grant until next grant
//   bus_penable/pready/prdata    shared-bus taps used to detect completion (WAIT only)
module apb_req_arbiter #(
    parameter int unsigned ADDWIDTH  = 8,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic                       req0_write,
    input  logic [ADDWIDTH:0]          req0_addr,
    input  logic [DATAWIDTH-1:0]       req0_wdata,
    input  logic [DATAWIDTH/8-1:0]     req0_strb,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic                       req1_write,
    input  logic [ADDWIDTH:0]          req1_addr,
    input  logic [DATAWIDTH-1:0]       req1_wdata,
    input  logic [DATAWIDTH/8-1:0]     req1_strb,
    output logic                       rsp0_valid,
    output logic [DATAWIDTH-1:0]       rsp0_rdata,
    output logic                       rsp0_err,
    output logic                       rsp1_valid,
    output logic [DATAWIDTH-1:0]       rsp1_rdata,
    output logic                       rsp1_err,
    output logic                       transfer,
    output logic                       m_pwrite,
    output logic [ADDWIDTH:0]          m_paddr,
    output logic [DATAWIDTH-1:0]       m_pwdata,
    output logic [DATAWIDTH/8-1:0]     m_pstrb,
    input  logic                       bus_penable,
    input  logic                       bus_pready,
    input  logic [DATAWIDTH-1:0]       bus_prdata
);

    localparam int unsigned AW = ADDWIDTH + 1;
    localparam int unsigned DW = DATAWIDTH;
    localparam int unsigned SW = DATAWIDTH / 8;
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            transfer_d;
    logic            m_pwrite_d;
    logic [AW-1:0]   m_paddr_d;
    logic [DW-1:0]   m_pwdata_d;
    logic [SW-1:0]   m_pstrb_d;

    logic            rsp0_valid_d, rsp0_err_d, rsp1_valid_d, rsp1_err_d;
    logic [DW-1:0]   rsp0_rdata_d, rsp1_rdata_d;

    logic            grant_sel_c;
    logic            finish_c;
    logic            err_sel_c;
    logic [DW-1:0]   rdata_sel_c;

    // Next-state, grant and response selection
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        transfer_d   = 1'b0;
        m_pwrite_d   = m_pwrite;
        m_paddr_d    = m_paddr;
        m_pwdata_d   = m_pwdata;
        m_pstrb_d    = m_pstrb;
        rsp0_valid_d = 1'b0;
        rsp0_rdata_d = '0;
        rsp0_err_d   = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp1_rdata_d = '0;
        rsp1_err_d   = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        grant_sel_c  = 1'b0;
        finish_c     = 1'b0;
        err_sel_c    = 1'b0;
        rdata_sel_c  = '0;

        case (state_q)
            IDLE: begin
                // Ready is suppressed while reset is asserted so no grant is reported
                if (!PRESET && (req0_valid || req1_valid)) begin
                    grant_sel_c  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    req0_ready   = ~grant_sel_c;
                    req1_ready   = grant_sel_c;
                    owner_d      = grant_sel_c;
                    last_grant_d = grant_sel_c;
                    m_pwrite_d   = grant_sel_c ? req1_write : req0_write;
                    m_paddr_d    = grant_sel_c ? req1_addr  : req0_addr;
                    m_pwdata_d   = grant_sel_c ? req1_wdata : req0_wdata;
                    m_pstrb_d    = grant_sel_c ? req1_strb  : req0_strb;
                    transfer_d   = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion wins over a simultaneous terminal count
                if (bus_penable && bus_pready) begin
                    finish_c    = 1'b1;
                    rdata_sel_c = m_pwrite ? '0 : bus_prdata;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    finish_c  = 1'b1;
                    err_sel_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (finish_c) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response is routed only to the owner; the other port stays at zero
        if (finish_c) begin
            rsp0_valid_d = ~owner_q;
            rsp0_rdata_d = owner_q ? '0 : rdata_sel_c;
            rsp0_err_d   = ~owner_q & err_sel_c;
            rsp1_valid_d = owner_q;
            rsp1_rdata_d = owner_q ? rdata_sel_c : '0;
            rsp1_err_d   = owner_q & err_sel_c;
        end
    end

    // State and registered outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            transfer     <= 1'b0;
            m_pwrite     <= 1'b0;
            m_paddr      <= '0;
            m_pwdata     <= '0;
            m_pstrb      <= '0;
            rsp0_valid   <= 1'b0;
            rsp0_rdata   <= '0;
            rsp0_err     <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_rdata   <= '0;
            rsp1_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            transfer     <= transfer_d;
            m_pwrite     <= m_pwrite_d;
            m_paddr      <= m_paddr_d;
            m_pwdata     <= m_pwdata_d;
            m_pstrb      <= m_pstrb_d;
            rsp0_valid   <= rsp0_valid_d;
            rsp0_rdata   <= rsp0_rdata_d;
            rsp0_err     <= rsp0_err_d;
            rsp1_valid   <= rsp1_valid_d;
            rsp1_rdata   <= rsp1_rdata_d;
            rsp1_err     <= rsp1_err_d;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter. The bench plays the shared bus and
// predicts each transaction's winner, response cycle and payload from the
// cycle-level timing rules (acceptance at T, completion at T+3+waits, timeout
// terminal count at T+1+TIMEOUT).
module tb_apb_req_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          req0_valid, req0_ready, req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic [SW-1:0] req0_strb;
    logic          req1_valid, req1_ready, req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [SW-1:0] req1_strb;
    logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          transfer, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata;
    logic [SW-1:0] m_pstrb;
    logic          bus_penable, bus_pready;
    logic [DW-1:0] bus_prdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_last;

    apb_req_arbiter #(.ADDWIDTH(8), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_strb(req0_strb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_strb(req1_strb),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .transfer(transfer), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
        .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
        .bus_penable(bus_penable), .bus_pready(bus_pready), .bus_prdata(bus_prdata)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".transfer"}, 64'(transfer), 64'(0));
        chk({tag, ".ready0"},   64'(req0_ready), 64'(0));
        chk({tag, ".ready1"},   64'(req1_ready), 64'(0));
        chk({tag, ".rsp0_v"},   64'(rsp0_valid), 64'(0));
        chk({tag, ".rsp0_d"},   64'(rsp0_rdata), 64'(0));
        chk({tag, ".rsp0_e"},   64'(rsp0_err), 64'(0));
        chk({tag, ".rsp1_v"},   64'(rsp1_valid), 64'(0));
        chk({tag, ".rsp1_d"},   64'(rsp1_rdata), 64'(0));
        chk({tag, ".rsp1_e"},   64'(rsp1_err), 64'(0));
        chk({tag, ".m_pwrite"}, 64'(m_pwrite), 64'(0));
        chk({tag, ".m_paddr"},  64'(m_paddr), 64'(0));
        chk({tag, ".m_pwdata"}, 64'(m_pwdata), 64'(0));
        chk({tag, ".m_pstrb"},  64'(m_pstrb), 64'(0));
    endtask

    // One complete transaction. ws = bus wait states after the first access
    // cycle (-1 = slave never ready). hold keeps both valids asserted throughout.
    task automatic txn(input string tag, input bit v0, input bit v1,
                       input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic [SW-1:0] s0,
                       input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [SW-1:0] s1,
                       input int ws, input logic [DW-1:0] rd, input bit hold);
        int win, rk, crel;
        logic ew, exp_err;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, exp_rd;
        logic [SW-1:0] es;
        @(posedge PCLK); #1;
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0; req0_strb = s0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1; req1_strb = s1;
        bus_penable = 1'b0; bus_pready = 1'b0; bus_prdata = '0;

        win = (v0 && v1) ? (exp_last ? 0 : 1) : (v1 ? 1 : 0);
        exp_last = (win == 1);
        ew = win ? w1 : w0; ea = win ? a1 : a0; ed = win ? d1 : d0; es = win ? s1 : s0;
        crel = (ws < 0) ? 1000 : 3 + ws;
        if (crel <= int'(TO) + 1) begin
            rk = crel + 1; exp_err = 1'b0; exp_rd = ew ? '0 : rd;
        end else begin
            rk = int'(TO) + 2; exp_err = 1'b1; exp_rd = '0;
        end

        @(negedge PCLK);
        chk({tag, ".grant0"}, 64'(req0_ready), 64'(win == 0));
        chk({tag, ".grant1"}, 64'(req1_ready), 64'(win == 1));

        for (int k = 1; k <= rk; k++) begin
            @(posedge PCLK); #1;
            if (!hold) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                req0_addr = AW'($urandom); req0_wdata = $urandom; req0_strb = SW'($urandom); req0_write = 1'($urandom);
                req1_addr = AW'($urandom); req1_wdata = $urandom; req1_strb = SW'($urandom); req1_write = 1'($urandom);
            end
            if (k == 1 || k == rk) begin
                // Bus activity outside WAIT must be ignored
                bus_penable = 1'b1; bus_pready = 1'b1; bus_prdata = $urandom;
            end else begin
                bus_penable = (k >= 3 && k <= crel);
                bus_pready  = (k == crel);
                bus_prdata  = (k == crel) ? rd : $urandom;
            end
            @(negedge PCLK);
            chk({tag, ".transfer"}, 64'(transfer), 64'(k == 1));
            chk({tag, ".noready0"}, 64'(req0_ready), 64'(0));
            chk({tag, ".noready1"}, 64'(req1_ready), 64'(0));
            chk({tag, ".m_pwrite"}, 64'(m_pwrite), 64'(ew));
            chk({tag, ".m_paddr"},  64'(m_paddr), 64'(ea));
            chk({tag, ".m_pwdata"}, 64'(m_pwdata), 64'(ed));
            chk({tag, ".m_pstrb"},  64'(m_pstrb), 64'(es));
            chk({tag, ".rsp0_v"}, 64'(rsp0_valid), 64'(k == rk && win == 0));
            chk({tag, ".rsp1_v"}, 64'(rsp1_valid), 64'(k == rk && win == 1));
            chk({tag, ".rsp0_d"}, 64'(rsp0_rdata), (k == rk && win == 0) ? 64'(exp_rd) : 64'(0));
            chk({tag, ".rsp1_d"}, 64'(rsp1_rdata), (k == rk && win == 1) ? 64'(exp_rd) : 64'(0));
            chk({tag, ".rsp0_e"}, 64'(rsp0_err), (k == rk && win == 0) ? 64'(exp_err) : 64'(0));
            chk({tag, ".rsp1_e"}, 64'(rsp1_err), (k == rk && win == 1) ? 64'(exp_err) : 64'(0));
        end
        bus_penable = 1'b0; bus_pready = 1'b0; bus_prdata = '0;
    endtask

    initial begin
        int ws, r;
        bit v0, v1;
        PRESET = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_strb = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_strb = '0;
        bus_penable = 1'b0; bus_pready = 1'b0; bus_prdata = '0;
        exp_last = 1'b1;

        // Reset state
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk_zero("reset");
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk_zero("post_reset");

        // Contention: grants alternate starting with req0
        for (int i = 0; i < 4; i++) begin
            txn("contend", 1'b1, 1'b1,
                1'b0, 9'h040, 32'h0, 4'h0,
                1'b1, 9'h141, 32'hCAFE0000 + 32'(i), 4'h3,
                i % 3, 32'hA5A50000 + 32'(i), 1'b1);
        end

        // Single read, zero-wait slave
        txn("single_rd", 1'b1, 1'b0, 1'b0, 9'h105, 32'h0, 4'h0,
            1'b0, 9'h000, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);

        // Write path from req1
        txn("write1", 1'b0, 1'b1, 1'b0, 9'h000, 32'h0, 4'h0,
            1'b1, 9'h00A, 32'h12345678, 4'hF, 1, 32'h55AA55AA, 1'b0);

        // Timeout, then a normal request
        txn("timeout", 1'b1, 1'b0, 1'b0, 9'h033, 32'h0, 4'h0,
            1'b0, 9'h000, 32'h0, 4'h0, -1, 32'h0, 1'b0);
        txn("after_to", 1'b0, 1'b1, 1'b0, 9'h000, 32'h0, 4'h0,
            1'b0, 9'h122, 32'h0, 4'h0, 2, 32'h0BADF00D, 1'b0);

        // Completion exactly at terminal count, and one cycle past it
        txn("to_edge", 1'b1, 1'b0, 1'b0, 9'h0F0, 32'h0, 4'h0,
            1'b0, 9'h000, 32'h0, 4'h0, int'(TO) - 2, 32'h13579BDF, 1'b0);
        txn("to_past", 1'b0, 1'b1, 1'b0, 9'h000, 32'h0, 4'h0,
            1'b0, 9'h1F0, 32'h0, 4'h0, int'(TO) - 1, 32'h2468ACE0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            r  = int'($urandom_range(0, 2));
            v0 = (r != 1);
            v1 = (r != 0);
            r  = int'($urandom_range(0, 9));
            if (r < 6)       ws = r % 4;
            else if (r < 9)  ws = 13 + (r - 6);
            else             ws = -1;
            txn("rand", v0, v1,
                1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                ws, $urandom, 1'($urandom));
        end

        // Reset during WAIT: transfer dropped, no response, arbitration restarts
        @(posedge PCLK); #1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h077;
        req1_valid = 1'b0;
        @(negedge PCLK);
        chk("rst_mid.accept", 64'(req0_ready), 64'(1));
        for (int k = 1; k <= 6; k++) begin
            @(posedge PCLK); #1;
            req0_valid = 1'b0;
            bus_penable = (k >= 3); bus_pready = 1'b0;
            @(negedge PCLK);
            chk("rst_mid.no_rsp", 64'(rsp0_valid), 64'(0));
        end
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        bus_penable = 1'b0;
        @(negedge PCLK);
        chk_zero("rst_mid");
        exp_last = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge PCLK); #1;
            bus_penable = 1'b1; bus_pready = 1'b1; bus_prdata = $urandom;
            @(negedge PCLK);
            chk("rst_mid.quiet_v0", 64'(rsp0_valid), 64'(0));
            chk("rst_mid.quiet_v1", 64'(rsp1_valid), 64'(0));
            chk("rst_mid.quiet_tr", 64'(transfer), 64'(0));
        end
        bus_penable = 1'b0; bus_pready = 1'b0;
        txn("rst_contend", 1'b1, 1'b1, 1'b0, 9'h011, 32'h0, 4'h0,
            1'b1, 9'h111, 32'h99999999, 4'hC, 0, 32'h76543210, 1'b1);
        txn("rst_contend2", 1'b1, 1'b1, 1'b0, 9'h011, 32'h0, 4'h0,
            1'b1, 9'h111, 32'h99999999, 4'hC, 0, 32'h76543210, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-port request arbiter and sequencer for the APB master. It accepts read and write commands from two independent requesters and grants them round-robin. It drives the master's command inputs (`transfer`, `PWRITEin`, `PADDRin`, `PWDATAin`, `PSTRBin`), monitors the shared bus for completion, and returns read data or a timeout error to the requester that owns the transfer. Only one APB transfer is outstanding at any time.

## Interface
- `ADDWIDTH`, default 8: APB address width. Command addresses are `ADDWIDTH+1` bits; the MSB selects the slave, as at the master's input.
- `DATAWIDTH`, default 32: data width. Strobe width is `DATAWIDTH/8`.
- `TIMEOUT`, default 16: maximum WAIT cycles before a transfer is abandoned. Must be ≥ 2.

Ports:
- `PCLK` in 1: the single clock. All logic is on its rising edge.
- `PRESET` in 1: synchronous, active-high reset.
- `reqN_valid` in 1 (N = 0, 1): requester N has a command.
- `reqN_ready` out 1: command accepted this cycle.
- `reqN_write` in 1: 1 = write, 0 = read.
- `reqN_addr` in `ADDWIDTH+1`: target address.
- `reqN_wdata` in `DATAWIDTH`: write data.
- `reqN_strb` in `DATAWIDTH/8`: write strobes.
- `rspN_valid` out 1: one-cycle response pulse to requester N.
- `rspN_rdata` out `DATAWIDTH`: read data. Valid with `rspN_valid`.
- `rspN_err` out 1: timeout flag. Valid with `rspN_valid`.
- `transfer` out 1: start pulse to the master.
- `m_pwrite` out 1: master command, write.
- `m_paddr` out `ADDWIDTH+1`: master command, address.
- `m_pwdata` out `DATAWIDTH`: master command, write data.
- `m_pstrb` out `DATAWIDTH/8`: master command, strobes.
- `bus_penable` in 1: bus `PENABLE` tap.
- `bus_pready` in 1: muxed bus `PREADY` tap.
- `bus_prdata` in `DATAWIDTH`: muxed bus `PRDATA` tap.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester: `reqN_ready`=1 combinationally in the same cycle.
  - Latch write, addr, wdata, strb and the owner ID into the `m_*` registers. Go to ISSUE.
  - With no valid request, stay in IDLE.
- **Arbitration**
  - With a single valid requester, that requester wins.
  - With both valid, the requester not granted last wins.
  - `last_grant` resets to 1, so req0 wins the first contention.
  - `last_grant` updates on every grant.
- **ISSUE**
  - `transfer`=1 for exactly this one cycle.
  - Clear the timeout counter. Go to WAIT.
- **WAIT**
  - Completion is `bus_penable && bus_pready`.
  - On completion: capture `bus_prdata` for reads (zero for writes), set err=0, go to RESP.
  - Otherwise the counter increments. When the counter equals `TIMEOUT-1` with no completion: rdata=0, err=1, go to RESP.
  - Completion on the same cycle as the timeout terminal count counts as completion (err=0).
- **RESP**
  - The owner's `rspN_valid`=1 for one cycle, with `rspN_rdata` and `rspN_err` driven. Go to IDLE.
  - The non-owner's rsp outputs stay at 0.
- `m_*` command outputs are held stable from ISSUE through RESP. They change only on a new grant.
- `bus_*` inputs are ignored outside WAIT.
- Requester valid may drop before ready with no effect. There is no response back-pressure; `rspN_valid` is always consumed.

## Timing
- **Reset** (synchronous; takes effect on the edge where `PRESET`=1, including mid-transfer):
  - State goes to IDLE and `last_grant` to 1.
  - `transfer`, `reqN_ready`, `rspN_valid`, `rspN_err`, `rspN_rdata`, all `m_*`, and the counter all go to 0.
  - Any in-flight command is dropped with no response.
- **Latency**: with acceptance in cycle T, `transfer` is high at T+1 and WAIT begins at T+2. For completion in cycle C, the response is in cycle C+1.
- With a zero-wait slave, the master completes at T+3, so the response is at T+4.
- **Timeout**: with no completion, the error response comes at T+2+`TIMEOUT`.
- **Throughput**: next acceptance no earlier than the cycle after RESP. Minimum spacing is 5 cycles with a zero-wait slave.
- `reqN_ready` is never high outside IDLE, and never high for both ports in the same cycle.

## Test plan
- **Single read**: req0 read with addr=0x105. Slave returns 0xDEADBEEF with zero wait → `req0_ready` at T, `transfer` at T+1, `m_paddr`=0x105, `rsp0_valid` at T+4 with rdata=0xDEADBEEF and err=0.
- **Contention round-robin**: req0 and req1 both hold valid for 4 transfers → grant order 0,1,0,1. Each `rspN_valid` goes only to its owner.
- **Write path**: req1 write with wdata=0x12345678, strb=0xF, addr=0x00A → `m_pwrite`=1 and the `m_*` fields are held through RESP. `rsp1_valid` comes with rdata=0, err=0.
- **Timeout**: `TIMEOUT`=16 and `bus_pready` held 0 → `rsp0_valid` with err=1, rdata=0 at T+18. The next request is then accepted normally.
- **Timeout boundary**: `bus_pready` rises exactly on the counter=15 cycle → err=0, and the captured data is returned.
- **Reset mid-op**: assert `PRESET` for 1 cycle during WAIT → all outputs are 0 next cycle and no rsp pulse occurs. A subsequent contention grants req0 first.
